// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The block side uses the slave modport; the producer/consumer side uses master.
interface pipelined_addsub_if #(
    parameter int N     = 16,
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic             cin;
    logic             sub;
    logic [TAG_W-1:0] tag_in;

    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     result;
    logic             carry;
    logic             overflow_flag;
    logic             negative;
    logic             zero;
    logic [TAG_W-1:0] tag_out;

    modport slave (
        input  in_valid, A, B, cin, sub, tag_in, out_ready,
        output in_ready, out_valid, result, carry, overflow_flag, negative, zero, tag_out
    );

    modport master (
        output in_valid, A, B, cin, sub, tag_in, out_ready,
        input  in_ready, out_valid, result, carry, overflow_flag, negative, zero, tag_out
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control, tag and flags.
// Define PIPELINED_ADDSUB_SATURATE_EN to clamp the result on signed overflow.
module pipelined_addsub #(
    parameter int N      = 16,
    parameter int SEG    = 2,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int NSEG = N / SEG;
    localparam int SPS  = NSEG / STAGES;
    localparam int LAST = STAGES - 1;
    localparam int PS   = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] st_v;
    logic              init_q;
    logic              accept;

    // intermediate stage registers (the final stage has its own output registers)
    logic [N-1:0]     pa_q [PS];
    logic [N-1:0]     pb_q [PS];
    logic [N-1:0]     pr_q [PS];
    logic             pc_q [PS];
    logic [TAG_W-1:0] pt_q [PS];

    logic [N-1:0]     st_a [STAGES];
    logic [N-1:0]     st_b [STAGES];
    logic [N-1:0]     st_r [STAGES];
    logic             st_c [STAGES];
    logic [TAG_W-1:0] st_t [STAGES];

    logic [N-1:0]     nx_r    [STAGES];
    logic             nx_c    [STAGES];
    logic             nx_cmsb [STAGES];

    logic [SEG-1:0]   seg_a;
    logic [SEG-1:0]   seg_b;
    logic [SEG-1:0]   s0;
    logic [SEG-1:0]   s1;
    logic             c0;
    logic             c1;
    logic             cy;
    int               lo;

    logic [N-1:0]     raw_res;
    logic [N-1:0]     sat_res;
    logic             raw_ovf;
    logic             raw_neg;

    logic [N-1:0]     result_q;
    logic             carry_q;
    logic             ovf_q;
    logic             neg_q;
    logic             zero_q;
    logic [TAG_W-1:0] tag_q;

    // A stage may load whenever it is empty or its occupant moves on this cycle.
    always_comb begin
        adv       = '0;
        load      = '0;
        adv[LAST]  = v_q[LAST] && bus.out_ready;
        load[LAST] = !v_q[LAST] || adv[LAST];
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k]  = v_q[k] && load[k+1];
            load[k] = !v_q[k] || adv[k];
        end
    end

    assign bus.in_ready = init_q && load[0];
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        st_v    = '0;
        st_v[0] = accept;
        st_a[0] = bus.A;
        st_b[0] = bus.sub ? ~bus.B : bus.B;
        st_r[0] = '0;
        st_c[0] = bus.sub | bus.cin;
        st_t[0] = bus.tag_in;
        for (int k = 1; k < STAGES; k++) begin
            st_v[k] = v_q[k-1];
            st_a[k] = pa_q[k-1];
            st_b[k] = pb_q[k-1];
            st_r[k] = pr_q[k-1];
            st_c[k] = pc_q[k-1];
            st_t[k] = pt_q[k-1];
        end
    end

    // Each segment forms both candidate sums and picks one with the ripple-in carry.
    always_comb begin
        seg_a = '0;
        seg_b = '0;
        s0    = '0;
        s1    = '0;
        c0    = 1'b0;
        c1    = 1'b0;
        cy    = 1'b0;
        lo    = 0;
        for (int k = 0; k < STAGES; k++) begin
            cy         = st_c[k];
            nx_r[k]    = st_r[k];
            nx_cmsb[k] = 1'b0;
            for (int j = 0; j < SPS; j++) begin
                lo       = (k * SPS + j) * SEG;
                seg_a    = st_a[k][lo +: SEG];
                seg_b    = st_b[k][lo +: SEG];
                {c0, s0} = {1'b0, seg_a} + {1'b0, seg_b};
                {c1, s1} = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, 1'b1};
                if (lo + SEG == N) begin
                    nx_cmsb[k] = seg_a[SEG-1] ^ seg_b[SEG-1] ^ (cy ? s1[SEG-1] : s0[SEG-1]);
                end
                nx_r[k][lo +: SEG] = cy ? s1 : s0;
                cy                 = cy ? c1 : c0;
            end
            nx_c[k] = cy;
        end
    end

    always_comb begin
        raw_res = nx_r[LAST];
        raw_ovf = nx_c[LAST] ^ nx_cmsb[LAST];
        raw_neg = raw_ovf ^ raw_res[N-1];
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        if (raw_ovf) begin
            sat_res = raw_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            sat_res = raw_res;
        end
`else
        sat_res = raw_res;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q   <= 1'b0;
            v_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            tag_q    <= '0;
            for (int k = 0; k < PS; k++) begin
                pa_q[k] <= '0;
                pb_q[k] <= '0;
                pr_q[k] <= '0;
                pc_q[k] <= 1'b0;
                pt_q[k] <= '0;
            end
        end else begin
            init_q <= 1'b1;
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= st_v[k];
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (load[k] && st_v[k]) begin
                    pa_q[k] <= st_a[k];
                    pb_q[k] <= st_b[k];
                    pr_q[k] <= nx_r[k];
                    pc_q[k] <= nx_c[k];
                    pt_q[k] <= st_t[k];
                end
            end
            if (load[LAST] && st_v[LAST]) begin
                result_q <= sat_res;
                carry_q  <= nx_c[LAST];
                ovf_q    <= raw_ovf;
                neg_q    <= raw_neg;
                zero_q   <= (sat_res == '0);
                tag_q    <= st_t[LAST];
            end
        end
    end

    assign bus.out_valid     = v_q[LAST];
    assign bus.result        = result_q;
    assign bus.carry         = carry_q;
    assign bus.overflow_flag = ovf_q;
    assign bus.negative      = neg_q;
    assign bus.zero          = zero_q;
    assign bus.tag_out       = tag_q;
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two's-complement fixed-point adder/subtractor for the ODE datapath. It generalises the combinational carry-select adder in three ways: configurable operand width, configurable pipeline depth, and an add/subtract mode. It also adds a valid/ready handshake with backpressure, a sideband tag and a zero flag. It sits between the operand fetch and the accumulate/update stages of the fixed-point solver and is the standard adder for all multi-cycle datapaths.

## Interface
Parameters:
- N, 16: operand and result width. Must be a multiple of SEG.
- SEG, 2: carry-select segment width in bits.
- STAGES, 4: number of pipeline register stages. Must divide N/SEG and be ≥1.
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- clk, input, 1: the single clock. All state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: the operand beat is valid.
- in_ready, output, 1: the block accepts the beat this cycle.
- A, input, N: operand A.
- B, input, N: operand B.
- cin, input, 1: carry-in. Used in add mode only.
- sub, input, 1: mode select. 0 computes A+B+cin; 1 computes A−B.
- tag_in, input, TAG_W: tag passed through unchanged with the operation.
- out_valid, output, 1: result beat is valid.
- out_ready, input, 1: downstream accepts the result.
- result, output, N: sum or difference.
- carry, output, 1: raw carry-out of the MSB segment.
- overflow_flag, output, 1: signed overflow.
- negative, output, 1: sign of the mathematically exact result.
- zero, output, 1: result is all zeros.
- tag_out, output, TAG_W: tag of the current result.

## Operation
- Effective operands:
  - B' = sub ? ~B : B.
  - c0 = sub ? 1 : cin.
- The N/SEG segments are split evenly across STAGES. Each stage holds (N/SEG)/STAGES segments.
- Each segment computes both candidate sums, for carry-in 0 and carry-in 1, then muxes on the incoming carry.
- Stage k registers:
  - the completed low result bits so far;
  - the carry into the next segment;
  - the not-yet-summed upper A and B' bits;
  - the tag;
  - a valid bit.
- Flags are computed in the final stage:
  - carry = carry-out of segment N/SEG−1.
  - overflow_flag = carry XOR carry into bit N−1.
  - negative = overflow_flag XOR result[N−1].
  - zero = (result == 0), after any saturation.
- Pipeline flow control:
  - Stage k loads from stage k−1 when stage k is empty, or when stage k is advancing this cycle.
  - The final stage advances when out_valid && out_ready.
  - Bubbles collapse: an empty stage never blocks the stages upstream of it.
  - in_ready = !valid[0] || stage 0 advancing.
  - A beat is accepted when in_valid && in_ready.
- The outputs are the final-stage registers. They hold stable while out_valid=1 and out_ready=0.
- tag_out always accompanies its own operation. The block never reorders beats.

## Timing
- Latency: STAGES cycles from acceptance to out_valid, with no stall.
- Throughput: 1 beat per cycle while out_ready=1.
- Reset (rst_n low, asynchronous):
  - all valid bits = 0, so out_valid=0;
  - result, tag_out = 0;
  - carry, overflow_flag, negative, zero = 0.
- While in reset, in_ready = 0. On the first clock after reset deassertion, in_ready = 1.
- Reset asserted mid-operation: every in-flight beat is discarded immediately. No partial result is ever presented.
- Full pipeline with out_ready=0: in_ready=0, and A, B and tag_in are ignored.
- Full pipeline with out_ready=1: accept and emit in the same cycle. in_ready stays 1.
- Simultaneous in_valid with a final-stage drain: both happen in that cycle, and occupancy is unchanged.
- With STAGES=1: combinational within the stage, one register, latency 1.

## Configuration
- PIPELINED_ADDSUB_SATURATE_EN:
  - Defined: on overflow_flag=1, result clamps.
    - Clamps to 2^(N−1)−1 when negative=0.
    - Clamps to −2^(N−1) when negative=1.
    - overflow_flag and carry still report the raw event.
    - zero reflects the clamped value, so zero=0.
  - Undefined: result is the wrapped modulo-2^N value. No clamp logic is present.

## Test plan
All cases use N=16 and STAGES=4.
- **Add with carry-in.** 0x1234 + 0x0001, cin=1, sub=0, tag=3.
  - Result after 4 cycles: result=0x1236, carry=0, overflow_flag=0, negative=0, zero=0, tag_out=3.
- **Signed overflow.** 0x7FFF + 0x0001, add.
  - overflow_flag=1, negative=0, carry=0.
  - Without the macro: result=0x8000.
  - With PIPELINED_ADDSUB_SATURATE_EN: result=0x7FFF.
- **Unsigned wrap and subtract-to-zero.**
  - 0xFFFF + 0x0001, cin=0 → result=0x0000, carry=1, overflow_flag=0, zero=1.
  - 0x0005 − 0x0005 → result=0x0000, carry=1, zero=1.
- **Negative subtraction.** 0x8000 − 0x0001.
  - overflow_flag=1, negative=1.
  - Without the macro: result=0x7FFF.
  - With the macro: result=0x8000, zero=0.
- **Backpressure.** Stream 8 beats with tags 0–7. Hold out_ready=0 from cycle 5 to cycle 9.
  - in_ready drops to 0 once 4 beats are held.
  - Outputs stay stable throughout the stall.
  - Results emerge in order 0–7 with no loss or duplication.
- **Reset mid-stream.** Assert rst_n=0 with 3 beats in flight.
  - out_valid=0 and all outputs=0 immediately, without waiting for a clock edge.
  - After release, one new beat gives the correct result after 4 cycles, with no stale beats emitted.
